// File: rtl/arb_pkg.sv
//============================================================================
// Module  : arb_pkg
// Purpose : Shared types and constants for the instruction/data memory port
//           arbiter: pending-read state encoding, default starvation limit
//           and small decode helpers.
// Config  : ARB_STARVE_GUARD_EN (consumed by mem_port_arbiter)
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

package arb_pkg;

  // Pending-read state: which port owns the SRAM read data next cycle.
  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE = 2'b00;
  localparam arb_state_t I_RD = 2'b01;
  localparam arb_state_t D_RD = 2'b10;

  // Consecutive lost arbitrations the fetch port tolerates by default.
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  // Width and ceiling of the starvation counter.
  localparam int unsigned STARVE_CNT_W = 3;
  localparam logic [STARVE_CNT_W-1:0] STARVE_CNT_MAX = '1;

  // A data access with no byte enables set is a load.
  function automatic logic is_load(input logic [3:0] wen);
    return (wen == 4'b0000);
  endfunction

  // Legal starvation limits are 1..7; anything else is a configuration error.
  function automatic logic limit_in_range(input int unsigned limit);
    return (limit >= 1) && (limit <= 7);
  endfunction

endpackage : arb_pkg

`default_nettype wire

// File: rtl/arb_starve_cnt.sv
//============================================================================
// Module  : arb_starve_cnt
// Purpose : Counts consecutive cycles in which the fetch port requests but is
//           not granted; raises starve_flag once the count reaches the limit
//           so the arbiter can hand the next slot to the fetch port.
// Config  : instantiated only when ARB_STARVE_GUARD_EN is defined
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

module arb_starve_cnt
  import arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic inst_req,
  input  logic inst_ack,
  output logic starve_flag
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] count_q;
  logic [STARVE_CNT_W-1:0] count_d;

  // Count a lost arbitration, saturating; any grant or idle cycle restarts.
  always_comb begin
    count_d = '0;
    if (inst_req && !inst_ack) begin
      count_d = (count_q == STARVE_CNT_MAX) ? count_q : count_q + 1'b1;
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign starve_flag = (count_q >= LIMIT);

endmodule : arb_starve_cnt

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//============================================================================
// Module  : mem_port_arbiter
// Purpose : Shares one single-port SRAM (1-cycle read latency) between a
//           fetch port and a load/store port. Grant and SRAM drive are
//           combinational in the requesting cycle; read data is steered to
//           the owning port one cycle later and held between deliveries.
//           Data normally wins; with the starvation guard built in, a fetch
//           port that has lost STARVE_LIMIT times in a row wins instead.
// Config  : ARB_STARVE_GUARD_EN  defined -> starvation guard present
//                                undefined -> strict data priority
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  // fetch port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ack,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  // load/store port
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ack,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  // SRAM
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  logic        starve_flag;
  logic        grant_inst;
  logic        grant_data;

  arb_state_t  state_q;
  arb_state_t  state_d;
  logic [31:0] inst_hold_q;
  logic [31:0] inst_hold_d;
  logic [31:0] data_hold_q;
  logic [31:0] data_hold_d;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk         (clk),
    .reset       (reset),
    .inst_req    (inst_req),
    .inst_ack    (inst_ack),
    .starve_flag (starve_flag)
  );
`else
  // Without the guard the limit has no effect; it only enters as a constant
  // zero term so the parameter stays referenced.
  localparam logic LIMIT_IN_RANGE = limit_in_range(STARVE_LIMIT);
  assign starve_flag = 1'b0 & LIMIT_IN_RANGE;
`endif

  // Arbitration: data first unless the fetch port is starving; nothing is
  // granted while reset is held so the SRAM stays quiet.
  always_comb begin
    grant_data = 1'b0;
    grant_inst = 1'b0;
    if (!reset) begin
      grant_data = data_req && !(starve_flag && inst_req);
      grant_inst = inst_req && !grant_data;
    end
  end

  assign inst_ack = grant_inst;
  assign data_ack = grant_data;

  // SRAM drive follows the winner; idle cycles present an all-zero bus.
  always_comb begin
    ram_en    = 1'b0;
    ram_wen   = 4'b0000;
    ram_addr  = 32'h0000_0000;
    ram_wdata = 32'h0000_0000;
    if (grant_data) begin
      ram_en    = 1'b1;
      ram_wen   = data_wen;
      ram_addr  = data_addr;
      ram_wdata = data_wdata;
    end else if (grant_inst) begin
      ram_en    = 1'b1;
      ram_addr  = inst_addr;
    end
  end

  // Next pending read: decided fresh every cycle, so reads can run
  // back-to-back and a delivery overlaps with the next grant.
  always_comb begin
    state_d = IDLE;
    if (grant_inst) begin
      state_d = I_RD;
    end else if (grant_data && is_load(data_wen)) begin
      state_d = D_RD;
    end
  end

  assign inst_rvalid = (state_q == I_RD);
  assign data_rvalid = (state_q == D_RD);

  // Each port's hold register captures the word delivered to it.
  always_comb begin
    inst_hold_d = inst_rvalid ? ram_rdata : inst_hold_q;
    data_hold_d = data_rvalid ? ram_rdata : data_hold_q;
  end

  assign inst_rdata = inst_rvalid ? ram_rdata : inst_hold_q;
  assign data_rdata = data_rvalid ? ram_rdata : data_hold_q;

  // State and hold registers; reset drops any read still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      inst_hold_q <= 32'h0000_0000;
      data_hold_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      inst_hold_q <= inst_hold_d;
      data_hold_q <= data_hold_d;
    end
  end

endmodule : mem_port_arbiter

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//============================================================================
// Module  : tb_mem_port_arbiter
// Purpose : Self-checking bench for mem_port_arbiter: directed scenarios
//           followed by randomized traffic, compared every cycle against a
//           behavioural model of the arbitration and SRAM contents.
// Config  : follows ARB_STARVE_GUARD_EN like the design
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ack(data_ack), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Environment SRAM: 16 words indexed by addr[5:2], 1-cycle read latency.
  logic [31:0] sram [16];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wen != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (ram_wen[b]) sram[ram_addr[5:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= sram[ram_addr[5:2]];
      end
    end
  end

  // Reference model: what should have been granted, what is in memory,
  // which port receives data next, and what each port last received.
  logic [31:0] ref_mem [16];
  int          pend;        // 0 none, 1 fetch, 2 data
  logic [31:0] m_rd;
  logic [31:0] m_hold_i;
  logic [31:0] m_hold_d;
  int          m_lost;      // consecutive fetch losses
  logic        eg_i, eg_d;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic m_starving();
`ifdef ARB_STARVE_GUARD_EN
    return (m_lost >= int'(LIMIT));
`else
    return 1'b0;
`endif
  endfunction

  // One clock: check mid-cycle, then advance the model at the edge.
  task automatic step();
    @(negedge clk);
    eg_d = !reset && data_req && !(m_starving() && inst_req);
    eg_i = !reset && inst_req && !eg_d;
    check("inst_ack", inst_ack, eg_i);
    check("data_ack", data_ack, eg_d);
    check("ram_en", ram_en, eg_i | eg_d);
    check("ram_wen", ram_wen, eg_d ? data_wen : 4'b0000);
    if (eg_i || eg_d) begin
      check("ram_addr", ram_addr, eg_d ? data_addr : inst_addr);
      check("ram_wdata", ram_wdata, eg_d ? data_wdata : 32'h0);
    end
    check("inst_rvalid", inst_rvalid, pend == 1);
    check("data_rvalid", data_rvalid, pend == 2);
    check("inst_rdata", inst_rdata, (pend == 1) ? m_rd : m_hold_i);
    check("data_rdata", data_rdata, (pend == 2) ? m_rd : m_hold_d);
    @(posedge clk);
    if (!reset) begin
      if (pend == 1) m_hold_i = m_rd;
      if (pend == 2) m_hold_d = m_rd;
      pend = 0;
      if (eg_i) begin
        m_rd = ref_mem[inst_addr[5:2]];
        pend = 1;
      end else if (eg_d && data_wen == 4'b0000) begin
        m_rd = ref_mem[data_addr[5:2]];
        pend = 2;
      end else if (eg_d) begin
        for (int b = 0; b < 4; b++)
          if (data_wen[b]) ref_mem[data_addr[5:2]][8*b +: 8] = data_wdata[8*b +: 8];
      end
      if (inst_req && !eg_i) m_lost = (m_lost < 7) ? m_lost + 1 : 7;
      else m_lost = 0;
    end
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    reset    = 1'b1;
    pend     = 0;
    m_hold_i = 32'h0;
    m_hold_d = 32'h0;
    m_lost   = 0;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  task automatic idle_ports();
    inst_req = 1'b0; data_req = 1'b0;
    data_wen = 4'b0000; data_wdata = 32'h0;
  endtask

  int inst_acks_seen;

  initial begin
    reset = 1'b1;
    inst_addr = 32'h0; data_addr = 32'h0;
    idle_ports();
    m_rd = 32'h0;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] v;
      v = $urandom;
      sram[i] = v;
      ref_mem[i] = v;
    end
    // Requests asserted during reset must not be granted.
    inst_req = 1'b1; data_req = 1'b1;
    apply_reset(3);
    idle_ports();
    step();

    // Boot fetch from an idle arbiter.
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    step();
    inst_req = 1'b0;
    step();

    // Fetch and load together: load first, fetch next cycle.
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    data_req = 1'b1; data_wen = 4'b0000; data_addr = 32'h8000_1000;
    step();
    data_req = 1'b0;
    step();
    inst_req = 1'b0;
    step();

    // Half-word store, then load it back.
    data_req = 1'b1; data_wen = 4'b0011; data_wdata = 32'h0000_BEEF;
    data_addr = 32'h8000_1008;
    step();
    data_wen = 4'b0000; data_wdata = 32'h0;
    step();
    data_req = 1'b0;
    step();

    // Both held high: the guard (when built in) lets fetch through.
    inst_req = 1'b1; inst_addr = 32'hBFC0_0010;
    data_req = 1'b1; data_wen = 4'b0000;
    inst_acks_seen = 0;
    for (int c = 0; c < 10; c++) begin
      data_addr = {$urandom} & 32'h0000_003C;
      step();
      if (eg_i) inst_acks_seen++;
    end
`ifdef ARB_STARVE_GUARD_EN
    check("starve_inst_acks", inst_acks_seen, 2);
`else
    check("starve_inst_acks", inst_acks_seen, 0);
`endif
    idle_ports();
    step();

    // Reset lands while a load's data is still pending.
    data_req = 1'b1; data_wen = 4'b0000; data_addr = 32'h8000_1010;
    step();
    data_req = 1'b0;
    apply_reset(2);
    step();
    step();

    // Alternating fetch/load reads back to back.
    for (int c = 0; c < 8; c++) begin
      inst_req = c[0];  inst_addr = 32'h0000_0040 + 32'(c * 4);
      data_req = !c[0]; data_addr = 32'h0000_0020 + 32'(c * 4);
      data_wen = 4'b0000;
      step();
    end
    idle_ports();
    step();
    step();

    // Randomized traffic; payload stays put until acked or withdrawn.
    for (int c = 0; c < 600; c++) begin
      step();
      if (eg_i || !inst_req) begin
        inst_req  = ($urandom_range(0, 99) < 60);
        inst_addr = $urandom;
      end else if ($urandom_range(0, 99) < 5) begin
        inst_req = 1'b0;
      end
      if (eg_d || !data_req) begin
        data_req   = ($urandom_range(0, 99) < 60);
        data_addr  = $urandom;
        data_wdata = $urandom;
        data_wen   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      end else if ($urandom_range(0, 99) < 5) begin
        data_req = 1'b0;
      end
      if (c == 300) begin
        apply_reset(1);
      end
    end
    idle_ports();
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mem_port_arbiter

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, consecutive lost arbitrations tolerated by inst port (legal 1..7).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset: clk in 1 (rising edge), reset in 1 (async, active-high).
REQ-003 inst_req  in  1  fetch request.
REQ-004 inst_addr  in  32  fetch byte address.
REQ-005 inst_ack  out  1  fetch granted this cycle.
REQ-006 inst_rvalid  out  1  fetch data valid.
REQ-007 inst_rdata  out  32  fetch data.
REQ-008 data_req  in  1  load/store request.
REQ-009 data_wen  in  4  byte write enables; 0 = load.
REQ-010 data_addr  in  32; data_wdata  in  32.
REQ-011 data_ack  out  1; data_rvalid  out  1; data_rdata  out  32.
REQ-012 ram_en  out  1; ram_wen  out  4; ram_addr  out  32; ram_wdata  out  32; ram_rdata  in  32 (single-port SRAM, 1-cycle read latency).

Function
REQ-013 The block SHALL grant at most one requester per cycle; grant, ack and ram_* drive are combinational in the requesting cycle.
REQ-014 Priority SHALL be data over inst, except when starve_flag is set, in which case inst wins.
REQ-015 On grant, ram_en=1, ram_addr/ram_wen/ram_wdata SHALL equal the winner's inputs (inst: ram_wen=0, ram_wdata=0); no grant -> ram_en=0, ram_wen=0.
REQ-016 Requesters SHALL hold req and payload stable until ack; a dropped req before ack is a legal withdrawal.
REQ-017 Pending-read FSM: states IDLE, I_RD, D_RD; next state = I_RD on inst grant, D_RD on data grant with data_wen=0, else IDLE; transitions every cycle (back-to-back allowed).
REQ-018 In I_RD, inst_rvalid=1 and inst_rdata=ram_rdata; in D_RD, data_rvalid=1 and data_rdata=ram_rdata; read latency exactly 1 cycle after ack.
REQ-019 Outside its rvalid cycle, each rdata output SHALL hold the last delivered value (hold register per port).
REQ-020 Stores (data_wen!=0) SHALL get ack only, never data_rvalid.
REQ-021 Starve counter (3 bits): increments when inst_req=1 and inst_ack=0; clears when inst_ack=1 or inst_req=0; saturates at 7.
REQ-022 starve_flag = (count >= STARVE_LIMIT).
REQ-023 Simultaneous rvalid (previous read) and new grant SHALL both occur in the same cycle without loss.

Reset
REQ-024 On reset: FSM=IDLE, counter=0, hold registers=0; all ack/rvalid/rdata outputs 0; ram_en=0 and ram_wen=0 while reset is high.
REQ-025 A read pending when reset asserts SHALL be discarded; no rvalid after reset release.

Configuration
REQ-026 Macro ARB_STARVE_GUARD_EN: defined -> REQ-021/022 active; undefined -> counter absent, starve_flag tied 0, strict data priority, STARVE_LIMIT ignored.

Structure
REQ-027 Shared package arb_pkg SHALL hold the FSM state typedef (IDLE=2'b00, I_RD=2'b01, D_RD=2'b10) and default STARVE_LIMIT constant.
REQ-028 One sub-module, arb_starve_cnt, SHALL implement REQ-021/022; it is instantiated only under ARB_STARVE_GUARD_EN.

Verification
REQ-029 Both ports idle, inst_req with inst_addr=0xBFC00000 -> same-cycle inst_ack, ram_addr=0xBFC00000; next cycle inst_rvalid=1, inst_rdata=ram_rdata.
REQ-030 inst_req and data_req (wen=0, addr=0x80001000) together -> data_ack, ram_addr=0x80001000, inst_ack=0; next cycle data_rvalid=1 and inst granted.
REQ-031 Store data_wen=4'b0011, data_wdata=0x0000BEEF -> ram_wen=0011, ram_wdata=0x0000BEEF, data_ack=1; next cycle data_rvalid=0.
REQ-032 Guard enabled, STARVE_LIMIT=4, data_req and inst_req held high -> data acked 4 cycles, inst acked on cycle 5, counter clears; guard disabled -> inst never acked.
REQ-033 Reset asserted the cycle after a data read grant -> no data_rvalid, all outputs 0, FSM=IDLE after release.
REQ-034 Alternating inst/data reads back-to-back -> each rvalid routed to the correct port, rdata outputs hold values between pulses.
